spike_event_encoder: RTL and testbench

Transmit side of the synapse event interface. The block collects parallel pre-synaptic spike pulses from the neuron layer and arbitrates them round-robin. It queues them as address events in a small FIFO and emits one event per cycle on `spike_out`/`addr_out`, together with `learn_out`/`delta_w_out`. Those outputs connect directly to the synapse array's `spike_in`, `neuron_addr`, `enable_learning` and `delta_w`. An optional STDP engine computes signed weight deltas from pre/post spike traces.

---
 rtl/spike_event_encoder.sv | 182 ++++++++++++++++++
 tb/tb_spike_event_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Spike event encoder: round-robin spike arbiter and event FIFO that drive the synapse event bus.
// Define STDP_DELTA_EN to build the optional STDP trace and weight-delta engine.
module spike_event_encoder #(
    parameter int NUM_SYNAPSES = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3,
    parameter int STDP_WINDOW  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SYNAPSES-1:0] spike_vec,
    input  logic                    post_spike,
    input  logic                    learn_en,
    input  logic                    hold,
    output logic                    spike_out,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic                    learn_out,
    output logic signed [7:0]       delta_w_out,
    output logic                    ltp_out,
    output logic [FIFO_AW:0]        fifo_count,
    output logic                    overflow,
    output logic                    busy
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  learn;
        logic signed [7:0]     delta;
        logic                  ltp;
    } event_t;

    logic [NUM_SYNAPSES-1:0] pend_q, pend_d;
    logic                    overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]        count_q, count_d;
    logic                    spike_out_q, spike_out_d;
    event_t                  out_q, out_d;
    event_t                  fifo_mem [FIFO_DEPTH];

    logic                    can_grant, grant_pre, grant_ltp, push, pop;
    logic                    pre_found;
    logic [ADDR_WIDTH-1:0]   pre_idx, grant_idx;
    logic [NUM_SYNAPSES-1:0] pre_mask;
    event_t                  push_entry;

    // Returns {found, index}: first requester at or after ptr, wrapping.
    function automatic logic [ADDR_WIDTH:0] rr_pick(input logic [NUM_SYNAPSES-1:0] req,
                                                    input logic [ADDR_WIDTH-1:0]   ptr);
        logic [ADDR_WIDTH:0] pick;
        int                  j;
        pick = '0;
        for (int k = NUM_SYNAPSES - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_SYNAPSES;
            if (req[j]) pick = {1'b1, ADDR_WIDTH'(j)};
        end
        return pick;
    endfunction

`ifdef STDP_DELTA_EN
    logic [3:0]              pre_tr_q [NUM_SYNAPSES];
    logic [3:0]              pre_tr_d [NUM_SYNAPSES];
    logic [3:0]              post_tr_q, post_tr_d, ltp_tr;
    logic [NUM_SYNAPSES-1:0] ltp_pend_q, ltp_pend_d, ltp_mask, pre_live;
    logic                    ltp_found;
    logic [ADDR_WIDTH-1:0]   ltp_idx;

    always_comb begin
        for (int i = 0; i < NUM_SYNAPSES; i++) begin
            if (spike_vec[i])           pre_tr_d[i] = 4'(STDP_WINDOW);
            else if (pre_tr_q[i] != '0) pre_tr_d[i] = pre_tr_q[i] - 1'b1;
            else                        pre_tr_d[i] = '0;
            pre_live[i] = (pre_tr_q[i] != '0);
        end
        if (post_spike)           post_tr_d = 4'(STDP_WINDOW);
        else if (post_tr_q != '0) post_tr_d = post_tr_q - 1'b1;
        else                      post_tr_d = '0;
        ltp_pend_d = (ltp_pend_q & ~ltp_mask) | ((post_spike && learn_en) ? pre_live : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYNAPSES; i++) pre_tr_q[i] <= '0;
            post_tr_q  <= '0;
            ltp_pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SYNAPSES; i++) pre_tr_q[i] <= pre_tr_d[i];
            post_tr_q  <= post_tr_d;
            ltp_pend_q <= ltp_pend_d;
        end
    end
`else
    logic unused_stdp_inputs;
    assign unused_stdp_inputs = ^{post_spike, learn_en};
`endif

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        {pre_found, pre_idx} = rr_pick(pend_q, rr_ptr_q);
        // A same-edge pop does not free a slot: only the registered count gates grants.
        can_grant  = (count_q < (FIFO_AW+1)'(FIFO_DEPTH));
        grant_pre  = can_grant && pre_found;
        grant_ltp  = 1'b0;
        grant_idx  = pre_idx;
        pre_mask   = grant_pre ? (NUM_SYNAPSES'(1) << pre_idx) : '0;
        push_entry = '0;
        push_entry.addr = pre_idx;
`ifdef STDP_DELTA_EN
        {ltp_found, ltp_idx} = rr_pick(ltp_pend_q, rr_ptr_q);
        grant_ltp = can_grant && (pend_q == '0) && ltp_found;
        ltp_mask  = grant_ltp ? (NUM_SYNAPSES'(1) << ltp_idx) : '0;
        ltp_tr    = (pre_tr_q[ltp_idx] == '0) ? 4'd1 : pre_tr_q[ltp_idx];
        if (grant_ltp) begin
            grant_idx        = ltp_idx;
            push_entry.addr  = ltp_idx;
            push_entry.learn = 1'b1;
            push_entry.delta = {4'b0, ltp_tr};
            push_entry.ltp   = 1'b1;
        end else begin
            push_entry.learn = learn_en && (post_tr_q != '0);
            push_entry.delta = -$signed({4'b0, post_tr_q});
        end
`endif
        push = grant_pre || grant_ltp;
        pop  = (count_q != '0) && !hold;

        pend_d     = (pend_q & ~pre_mask) | spike_vec;
        overflow_d = overflow_q | (|(spike_vec & pend_q & ~pre_mask));
        rr_ptr_d   = rr_ptr_q;
        if (push)
            rr_ptr_d = (grant_idx == ADDR_WIDTH'(NUM_SYNAPSES - 1)) ? '0 : grant_idx + 1'b1;

        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        spike_out_d = pop;
        out_d       = pop ? fifo_mem[rd_ptr_q] : out_q;
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            overflow_q  <= 1'b0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            spike_out_q <= 1'b0;
            out_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            overflow_q  <= overflow_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            spike_out_q <= spike_out_d;
            out_q       <= out_d;
        end
    end

    // NOTE: FIFO storage is not reset; reset pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    assign spike_out   = spike_out_q;
    assign addr_out    = out_q.addr;
    assign learn_out   = out_q.learn;
    assign delta_w_out = out_q.delta;
    assign ltp_out     = out_q.ltp;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
`ifdef STDP_DELTA_EN
    assign busy = (|pend_q) || (|ltp_pend_q) || (count_q != '0);
`else
    assign busy = (|pend_q) || (count_q != '0);
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Scoreboard bench for spike_event_encoder: stimulus pushes expected events, a monitor pops and compares.
module tb_spike_event_encoder;

    localparam int N = 16;

    logic              clk = 1'b0;
    logic              rst, post_spike, learn_en, hold;
    logic [N-1:0]      spike_vec;
    logic              spike_out, learn_out, ltp_out, overflow, busy;
    logic [3:0]        addr_out;
    logic signed [7:0] delta_w_out;
    logic [3:0]        fifo_count;

    int          total = 0;
    int          bad   = 0;
    logic [13:0] exp_q [$];

    always #5 clk = ~clk;

    spike_event_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .spike_vec   (spike_vec),
        .post_spike  (post_spike),
        .learn_en    (learn_en),
        .hold        (hold),
        .spike_out   (spike_out),
        .addr_out    (addr_out),
        .learn_out   (learn_out),
        .delta_w_out (delta_w_out),
        .ltp_out     (ltp_out),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] mk(input int addr, input logic learn, input int delta, input logic ltp);
        return {4'(addr), learn, 8'(delta), ltp};
    endfunction

    task automatic push_seq(input int start);
        for (int k = 0; k < N; k++) exp_q.push_back(mk((start + k) % N, 1'b0, 0, 1'b0));
    endtask

    task automatic wait_drain(input string name);
        int  cyc;
        logic done;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (exp_q.size() == 0 && !busy && !spike_out) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every event strobe must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        logic [13:0] e;
        if (!rst && spike_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got addr=%0d with empty scoreboard", addr_out);
            end else begin
                e = exp_q.pop_front();
                check("event", {18'd0, addr_out, learn_out, delta_w_out, ltp_out}, {18'd0, e});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sum;
        rst = 1'b1; spike_vec = '0; post_spike = 1'b0; learn_en = 1'b0; hold = 1'b0;
        tick(); tick();
        check("rst_outputs", {spike_out, addr_out, learn_out, delta_w_out, ltp_out}, 32'd0);
        check("rst_status", {fifo_count, overflow, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Burst from rr_ptr=0: 16 back-to-back events, addresses 0..15.
        push_seq(0);
        spike_vec = 16'hFFFF; tick(); spike_vec = '0;
        tick(); tick();
        sum = 0;
        for (int k = 0; k < N; k++) begin
            sum += int'(spike_out);
            tick();
        end
        check("burst_contiguous", sum, 16);
        check("burst_overflow", {31'd0, overflow}, 32'd0);
        wait_drain("burst_drain");

        // Single spike latency: strobe visible only after E2.
        exp_q.push_back(mk(2, 1'b0, 0, 1'b0));
        spike_vec = 16'h0004; tick(); spike_vec = '0;
        check("lat_e0", {31'd0, spike_out}, 32'd0);
        tick();
        check("lat_e1", {31'd0, spike_out}, 32'd0);
        check("lat_e1_count", {28'd0, fifo_count}, 32'd1);
        tick();
        check("lat_e2", {31'd0, spike_out}, 32'd1);
        wait_drain("single_drain");

        // Round-robin: last grant 5, then {3,7} -> 7 first, then 3.
        exp_q.push_back(mk(5, 1'b0, 0, 1'b0));
        spike_vec = 16'h0020; tick(); spike_vec = '0;
        wait_drain("rr_setup_drain");
        exp_q.push_back(mk(7, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(3, 1'b0, 0, 1'b0));
        spike_vec = 16'h0088; tick(); spike_vec = '0;
        wait_drain("rr_drain");

        // Hold: FIFO fills to 8 (4..11), bit 0 stays pending and merges two more pulses.
        push_seq(4);
        hold = 1'b1;
        spike_vec = 16'hFFFF; tick(); spike_vec = '0;
        for (int k = 0; k < 10; k++) tick();
        check("hold_full_count", {28'd0, fifo_count}, 32'd8);
        check("hold_no_strobe", {31'd0, spike_out}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);
        check("hold_overflow_pre", {31'd0, overflow}, 32'd0);
        spike_vec = 16'h0001; tick(); spike_vec = '0; tick();
        spike_vec = 16'h0001; tick(); spike_vec = '0; tick();
        check("merge_overflow", {31'd0, overflow}, 32'd1);
        hold = 1'b0;
        wait_drain("merge_drain");
        check("overflow_sticky", {31'd0, overflow}, 32'd1);
        check("idle_count", {28'd0, fifo_count}, 32'd0);

        // Reset mid-traffic: everything clears and no further events appear.
        push_seq(4);
        spike_vec = 16'hFFFF; tick(); spike_vec = '0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1; tick();
        exp_q.delete();
        check("midrst_outputs", {spike_out, addr_out, learn_out, delta_w_out, ltp_out}, 32'd0);
        check("midrst_status", {fifo_count, overflow, busy}, 32'd0);
        rst = 1'b0;
        sum = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            sum += int'(spike_out);
        end
        check("midrst_silent", sum, 0);
        check("midrst_busy", {31'd0, busy}, 32'd0);

`ifdef STDP_DELTA_EN
        // post_spike at E, pre spike at E+2 -> grant at E+3 with delta -13;
        // post_spike at E+5 while pre_tr[1]=13 -> LTP event with delta +12.
        learn_en = 1'b1;
        exp_q.push_back(mk(1, 1'b1, -13, 1'b0));
        exp_q.push_back(mk(1, 1'b1, 12, 1'b1));
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        tick();
        spike_vec = 16'h0002; tick(); spike_vec = '0;
        check("stdp_pre_grant_wait", {28'd0, fifo_count}, 32'd0);
        tick();
        check("stdp_pre_grant_e3", {28'd0, fifo_count}, 32'd1);
        tick();
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        wait_drain("stdp_drain");
        learn_en = 1'b0;
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
